// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared pointer/depth helpers for the RAM-backed single-clock FIFO.
package ram_fifo_pkg;
   localparam int DEF_ADDR_WIDTH = 4;
   function automatic int ptr_width(input int aw);
      return aw + 1;
   endfunction
   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction
   localparam int PTR_WIDTH = ptr_width(DEF_ADDR_WIDTH);
   localparam int DEPTH = depth(DEF_ADDR_WIDTH);
   typedef logic [PTR_WIDTH-1:0] ptr_t;
   // Words between two wrap-bit pointers, modulo 2**(aw+1).
   function automatic logic [31:0] avail(input logic [31:0] wr, input logic [31:0] rd, input int aw);
      return (wr - rd) & ((32'd1 << (aw + 1)) - 32'd1);
   endfunction
endpackage

// File: rtl/ram_rd_skid.sv
// ram_rd_skid: 2-entry output buffer; head is registered and drives the stream.
module ram_rd_skid #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic                  i_clear,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_cnt
);
   logic [1:0]            r_cnt;
   logic [DATA_WIDTH-1:0] r_d0;
   logic [DATA_WIDTH-1:0] r_d1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_d0  <= '0;
         r_d1  <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else begin
         if (i_pop)
            r_d0 <= (r_cnt == 2'd2) ? r_d1 : i_data;
         else if (i_push && r_cnt == 2'd0)
            r_d0 <= i_data;
         if (i_push && (i_pop ? r_cnt == 2'd2 : r_cnt == 2'd1))
            r_d1 <= i_data;
         r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
      end
   end
   assign o_valid = (r_cnt != 2'd0);
   assign o_data  = r_d0;
   assign o_cnt   = r_cnt;
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: drains a dual-port RAM via port B into a valid/ready stream,
// returning its read pointer so the producer can detect full.
module ram_stream_reader
   import ram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH:0]   wr_ptr,
   output logic [ADDR_WIDTH:0]   rd_ptr,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   output logic                  ram_enb,
   input  logic [DATA_WIDTH-1:0] ram_doutb,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   input  logic                  flush,
   output logic                  empty,
   output logic                  ovf_err
);
   localparam int PW = ptr_width(ADDR_WIDTH);
   localparam int LDEPTH = depth(ADDR_WIDTH);
   logic [PW-1:0] r_rd_ptr;
   logic          r_pend;
   logic          r_ovf;
   logic [PW-1:0] w_avail;
   logic [1:0]    w_cnt;
   logic [2:0]    w_load;
   logic          w_pop;
   logic          w_enb;
   assign w_avail = PW'(avail(32'(wr_ptr), 32'(r_rd_ptr), ADDR_WIDTH));
   assign w_pop   = m_valid && m_ready;
   // Slots committed after this edge: buffered plus in flight, less the word leaving now.
   assign w_load  = {1'b0, w_cnt} + {2'b0, r_pend} - {2'b0, w_pop};
   assign w_enb   = rst_n && !flush && (w_avail != '0) && (w_load < 3'd2);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_pend   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (flush) begin
         r_rd_ptr <= wr_ptr;
         r_pend   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_pend <= w_enb;
         if (w_enb)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_avail > PW'(LDEPTH))
            r_ovf <= 1'b1;
      end
   end
   ram_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_pend),
      .i_pop   (w_pop),
      .i_clear (flush),
      .i_data  (ram_doutb),
      .o_valid (m_valid),
      .o_data  (m_data),
      .o_cnt   (w_cnt)
   );
   assign rd_ptr    = r_rd_ptr;
   assign ram_addrb = r_rd_ptr[ADDR_WIDTH-1:0];
   assign ram_enb   = w_enb;
   assign empty     = (w_avail == '0) && (w_cnt == 2'd0) && !r_pend;
   assign ovf_err   = r_ovf;
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
Read-side controller for the team's simple dual-port RAM. It consumes the RAM's port-B read interface (address, enable, registered data with 1-cycle latency). It turns the entries a producer has written on port A into a valid/ready output stream for the UART TX path. The producer publishes a write pointer and this block publishes its read pointer back, so the pair forms a single-clock FIFO.

Parameters:
DATA_WIDTH, 16, width of RAM word and stream data
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH

Ports:
clk  input  1  single clock; RAM clkb is tied to this clock
rst_n  input  1  asynchronous active-low reset
wr_ptr  input  ADDR_WIDTH+1  producer write pointer; extra MSB is the wrap bit; same clock domain
rd_ptr  output  ADDR_WIDTH+1  read pointer returned to producer for full detection
ram_addrb  output  ADDR_WIDTH  RAM port-B address, equal to rd_ptr[ADDR_WIDTH-1:0]
ram_enb  output  1  RAM port-B read enable; one read is issued per cycle it is high
ram_doutb  input  DATA_WIDTH  RAM registered read data; valid the cycle after ram_enb
m_valid  output  1  stream data valid
m_data  output  DATA_WIDTH  stream data (head of buffer)
m_ready  input  1  downstream accept; transfer when m_valid&&m_ready
flush  input  1  synchronous discard of all unread data
empty  output  1  high when nothing is buffered, in flight or available in RAM
ovf_err  output  1  sticky: wr_ptr-rd_ptr exceeded depth

Behaviour:
- Reset (rst_n low, async): rd_ptr=0, buffer count=0, pending=0, m_valid=0, m_data=0, ovf_err=0. ram_enb is forced 0 while rst_n is low.
- avail = (wr_ptr - rd_ptr) mod 2**(ADDR_WIDTH+1). Legal range is 0..2**ADDR_WIDTH.
- Output buffer: 2 entries (cnt 0..2). pend = 1 when a read was issued on the previous edge.
- pop = m_valid && m_ready.
- Issue condition: ram_enb = !flush && avail!=0 && (cnt + pend - pop) < 2. ram_enb is combinational from registered state and inputs.
- On an issue edge: rd_ptr <= rd_ptr+1 with modulo wrap across 2**(ADDR_WIDTH+1). Slot release happens at issue because the RAM has already latched the word at that edge.
- Capture: on the edge after an issue (pend=1), ram_doutb is written into the buffer tail. If pop occurs on the same edge, the head shifts and the tail is written in one step. Count stays unchanged.
- m_valid = (cnt != 0). m_data = head entry, registered.
- Latency: wr_ptr increments at edge e. ram_enb is high in the cycle after e. m_valid rises after edge e+2.
- Throughput: 1 word/cycle sustained with m_ready held high.
- Empty: avail=0, cnt=0, pend=0 → empty=1, ram_enb=0. Full RAM (avail=2**ADDR_WIDTH) is legal and is read normally.
- Backpressure: with m_ready low, at most 2 words are held (buffer plus in-flight). No further reads are issued and rd_ptr stalls.
- flush has priority over issue, capture and pop. On the flush edge: rd_ptr <= wr_ptr, cnt <= 0, pend <= 0, ovf_err <= 0. ram_enb is 0 during the flush cycle, and m_valid is 0 from the next cycle. Data returning from a pre-flush read is dropped.
- ovf_err is set when avail > 2**ADDR_WIDTH and is held until reset or flush. While it is set, reads continue; behaviour is undefined.
- Reset mid-transfer drops buffered and in-flight data immediately. rd_ptr returns to 0; the producer is expected to reset together with this block.

Decomposition:
- Package ram_fifo_pkg: ptr width constant derivation helper, ptr_t typedef (ADDR_WIDTH+1 bits), an avail() function for modulo subtraction, and a DEPTH localparam convention.
- Sub-module ram_rd_skid: the 2-entry output buffer with push/pop/clear, parameterised on DATA_WIDTH. The top block keeps the pointers, issue logic, pend flag and error flag.

Test Plan:
- Reset: hold rst_n low with wr_ptr=3 → ram_enb=0, m_valid=0, rd_ptr=0. After release, words 0..2 stream out. The first m_valid is 2 cycles after the first ram_enb-eligible cycle.
- Streaming: producer writes 0xA000..0xA00F (16 words, fills RAM, avail=16), m_ready=1 → 16 consecutive beats in order. rd_ptr wraps 15→16. empty=1 at the end.
- Backpressure: 5 words, m_ready=0 for 10 cycles → exactly 2 ram_enb pulses and rd_ptr=2. After m_ready=1, the remaining 3 words follow back-to-back with no loss or duplication.
- Random m_ready (50%) over 200 words with pointer wrap → scoreboard matches in order. ovf_err stays 0.
- Flush: 6 words queued, 1 word popped, flush pulsed with a read in flight → next cycle m_valid=0, rd_ptr==wr_ptr, empty=1. The in-flight word never appears.
- Error: force wr_ptr = rd_ptr+17 → ovf_err=1 on the next edge, held until flush clears it.
